// File: rtl/mdl_sdevlink_if.sv
// Signal bundle between the device OOB/detect models, mdl_sdevlink and the device link layer.
// master = environment side (drives i_*), slave = mdl_sdevlink (drives o_*).
interface mdl_sdevlink_if #(
  parameter int P_BITS  = 40,
  parameter int RETRY_W = 2
);
  logic               i_comreset;
  logic               i_comwake;
  logic               i_oob_done;
  logic [P_BITS-1:0]  i_rx_data;
  logic [P_BITS-1:0]  i_tx_data;
  logic               o_cominit;
  logic               o_comwake;
  logic               o_tx_oob;
  logic [P_BITS-1:0]  o_tx_data;
  logic               o_tx_ready;
  logic               o_link_up;
  logic               o_reset;
  logic               o_error;
  logic [RETRY_W-1:0] o_retries;

  modport master (
    output i_comreset, i_comwake, i_oob_done, i_rx_data, i_tx_data,
    input  o_cominit, o_comwake, o_tx_oob, o_tx_data, o_tx_ready,
           o_link_up, o_reset, o_error, o_retries
  );

  modport slave (
    input  i_comreset, i_comwake, i_oob_done, i_rx_data, i_tx_data,
    output o_cominit, o_comwake, o_tx_oob, o_tx_data, o_tx_ready,
           o_link_up, o_reset, o_error, o_retries
  );
endinterface

// File: rtl/mdl_sdevlink.sv
// Device-side SATA link bring-up: COMRESET -> COMINIT -> COMWAKE -> ALIGN/SYNC exchange -> READY.
// Define MDL_SDEVLINK_ALIGN_INSERT_EN to insert ALIGN pairs every ALIGN_INTV words in READY.
//
// state       | meaning
// IDLE        | line idle, waiting for host COMRESET
// SEND_INIT   | COMINIT burst requested, waiting for oob_done
// AWAIT_WAKE  | waiting for host COMWAKE; timeout retries COMINIT or goes to ERROR
// SEND_WAKE   | COMWAKE burst requested, waiting for oob_done
// AWAIT_ALIGN | sending ALIGN, waiting for an ALIGN word from the host
// AWAIT_SYNC  | sending SYNC, counting consecutive received SYNC words
// READY       | link up, link-layer words passed to the serialiser
// ERROR       | retries exhausted, held until COMRESET
module mdl_sdevlink #(
  parameter int NPRIM      = 1,
  parameter int TIMEOUT    = 1024,
  parameter int MAX_RETRY  = 3,
  parameter int SYNC_CNT   = 4,
  parameter int ALIGN_INTV = 256
) (
  input  logic          i_txclk,
  input  logic          i_reset,
  mdl_sdevlink_if.slave lnk
);
  localparam int P_BITS  = 40 * NPRIM;
  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int TMR_W   = $clog2(TIMEOUT + 1);
  localparam int SCNT_W  = $clog2(SYNC_CNT + 1);

  localparam logic [TMR_W-1:0]   TMR_LAST  = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0]   TMR_SAT   = TMR_W'(TIMEOUT);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
  localparam logic [SCNT_W-1:0]  SYNC_LAST = SCNT_W'(SYNC_CNT - 1);

  // 10-bit characters, first-transmitted character in the LSBs
  localparam logic [9:0] K28_5 = 10'b0011111010;
  localparam logic [9:0] K28_3 = 10'b0011110011;
  localparam logic [9:0] D10_2 = 10'b0101010101;
  localparam logic [9:0] D27_3 = 10'b1101100011;
  localparam logic [9:0] D21_5 = 10'b1010101010;
  localparam logic [9:0] D21_4 = 10'b1010101101;

  localparam logic [39:0] ALIGN_P = {D27_3, D10_2, D10_2, K28_5};
  localparam logic [39:0] SYNC_P  = {D21_5, D21_5, D21_4, K28_3};
  localparam logic [P_BITS-1:0] ALIGN_W = {NPRIM{ALIGN_P}};
  localparam logic [P_BITS-1:0] SYNC_W  = {NPRIM{SYNC_P}};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_INIT,
    ST_AWAIT_WAKE,
    ST_SEND_WAKE,
    ST_AWAIT_ALIGN,
    ST_AWAIT_SYNC,
    ST_READY,
    ST_ERROR
  } state_t;

  state_t            state;
  state_t            nxt;
  logic [TMR_W-1:0]  timer;
  logic [SCNT_W-1:0] sync_cnt;
  logic              tmo;
  logic              rx_align;
  logic              rx_sync;
  logic              sync_done;
  logic              retry;
  logic              tx_ready_nxt;

  assign tmo       = (timer == TMR_LAST);
  assign rx_align  = (lnk.i_rx_data == ALIGN_W);
  assign rx_sync   = (lnk.i_rx_data == SYNC_W);
  assign sync_done = rx_sync && (sync_cnt == SYNC_LAST);

  // COMRESET overrides every other event in every state
  always_comb begin
    nxt   = state;
    retry = 1'b0;
    if (lnk.i_comreset) begin
      nxt = ST_SEND_INIT;
    end else begin
      case (state)
        ST_SEND_INIT: if (lnk.i_oob_done) nxt = ST_AWAIT_WAKE;
        ST_AWAIT_WAKE: begin
          if (lnk.i_comwake) begin
            nxt = ST_SEND_WAKE;
          end else if (tmo) begin
            if (lnk.o_retries < RETRY_MAX) begin
              nxt   = ST_SEND_INIT;
              retry = 1'b1;
            end else begin
              nxt = ST_ERROR;
            end
          end
        end
        ST_SEND_WAKE: if (lnk.i_oob_done) nxt = ST_AWAIT_ALIGN;
        ST_AWAIT_ALIGN: begin
          if (rx_align)  nxt = ST_AWAIT_SYNC;
          else if (tmo)  nxt = ST_IDLE;
        end
        ST_AWAIT_SYNC: begin
          if (sync_done) nxt = ST_READY;
          else if (tmo)  nxt = ST_IDLE;
        end
        default: ;
      endcase
    end
  end

`ifdef MDL_SDEVLINK_ALIGN_INSERT_EN
  localparam int INS_W = (ALIGN_INTV > 1) ? $clog2(ALIGN_INTV) : 1;
  localparam logic [INS_W-1:0] INS_LAST = INS_W'(ALIGN_INTV - 1);

  logic [INS_W-1:0] ins_cnt;
  logic [1:0]       ins_left;
  logic             consume;
  logic             ins_start;

  assign consume   = (state == ST_READY) && lnk.o_tx_ready;
  assign ins_start = consume && (ins_cnt == INS_LAST);

  // ins_left counts the two ALIGN slots; both counters restart on READY entry
  always_ff @(posedge i_txclk) begin
    if (i_reset || state != ST_READY) begin
      ins_cnt  <= '0;
      ins_left <= '0;
    end else begin
      if (consume) ins_cnt <= ins_start ? '0 : ins_cnt + 1'b1;
      if (ins_start)            ins_left <= 2'd2;
      else if (ins_left != '0)  ins_left <= ins_left - 1'b1;
    end
  end

  assign tx_ready_nxt = (nxt == ST_READY) && !ins_start && (ins_left != 2'd2);
`else
  logic unused_intv;
  assign unused_intv  = (ALIGN_INTV != 0);
  assign tx_ready_nxt = (nxt == ST_READY);
`endif

  always_ff @(posedge i_txclk) begin
    if (i_reset) begin
      state          <= ST_IDLE;
      timer          <= '0;
      sync_cnt       <= '0;
      lnk.o_cominit  <= 1'b0;
      lnk.o_comwake  <= 1'b0;
      lnk.o_tx_oob   <= 1'b1;
      lnk.o_tx_data  <= '0;
      lnk.o_tx_ready <= 1'b0;
      lnk.o_link_up  <= 1'b0;
      lnk.o_error    <= 1'b0;
      lnk.o_retries  <= '0;
    end else begin
      state <= nxt;

      if (lnk.i_comreset || nxt != state) timer <= '0;
      else if (timer != TMR_SAT)          timer <= timer + 1'b1;

      if (state == ST_AWAIT_SYNC && rx_sync) sync_cnt <= sync_cnt + 1'b1;
      else                                   sync_cnt <= '0;

      if (lnk.i_comreset) lnk.o_retries <= '0;
      else if (retry)     lnk.o_retries <= lnk.o_retries + 1'b1;

      lnk.o_cominit  <= lnk.i_comreset || retry;
      lnk.o_comwake  <= (state == ST_AWAIT_WAKE) && (nxt == ST_SEND_WAKE);
      lnk.o_tx_oob   <= !(nxt inside {ST_AWAIT_ALIGN, ST_AWAIT_SYNC, ST_READY});
      lnk.o_link_up  <= (nxt == ST_READY);
      lnk.o_error    <= (nxt == ST_ERROR);
      lnk.o_tx_ready <= tx_ready_nxt;

      // a READY cycle without tx_ready is always an inserted ALIGN slot
      case (nxt)
        ST_AWAIT_ALIGN: lnk.o_tx_data <= ALIGN_W;
        ST_AWAIT_SYNC:  lnk.o_tx_data <= SYNC_W;
        ST_READY: begin
          if (state != ST_READY)    lnk.o_tx_data <= SYNC_W;
          else if (lnk.o_tx_ready)  lnk.o_tx_data <= lnk.i_tx_data;
          else                      lnk.o_tx_data <= ALIGN_W;
        end
        default:        lnk.o_tx_data <= '0;
      endcase
    end
  end

  assign lnk.o_reset = ~lnk.o_link_up;

endmodule

// File: tb/tb_mdl_sdevlink.sv
// Randomised bench for mdl_sdevlink: DUT A (NPRIM=1, retries, SYNC counting, data path)
// and DUT B (NPRIM=2, MAX_RETRY=0, SYNC_CNT=1).
module tb_mdl_sdevlink;
  localparam int TO_A = 32;
  localparam int MR_A = 3;
  localparam int SC_A = 4;
  localparam int INTV = 8;
  localparam int TO_B = 16;
`ifdef MDL_SDEVLINK_ALIGN_INSERT_EN
  localparam bit INS_EN = 1'b1;
`else
  localparam bit INS_EN = 1'b0;
`endif

  localparam logic [39:0] ALIGN_P = {10'b1101100011, 10'b0101010101, 10'b0101010101, 10'b0011111010};
  localparam logic [39:0] SYNC_P  = {10'b1010101010, 10'b1010101010, 10'b1010101101, 10'b0011110011};

  // {cominit, comwake, tx_oob, tx_ready, link_up, reset, error}
  localparam logic [6:0] S_IDLE  = 7'b0010010;
  localparam logic [6:0] S_INIT  = 7'b1010010;
  localparam logic [6:0] S_WAKE  = 7'b0110010;
  localparam logic [6:0] S_LINE  = 7'b0000010;
  localparam logic [6:0] S_UP    = 7'b0001100;
  localparam logic [6:0] S_ERR   = 7'b0010011;

  logic i_txclk = 1'b0;
  logic i_reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 i_txclk = ~i_txclk;

  mdl_sdevlink_if #(.P_BITS(40), .RETRY_W(2)) ifa ();
  mdl_sdevlink_if #(.P_BITS(80), .RETRY_W(1)) ifb ();

  mdl_sdevlink #(.NPRIM(1), .TIMEOUT(TO_A), .MAX_RETRY(MR_A), .SYNC_CNT(SC_A), .ALIGN_INTV(INTV))
    u_dut_a (.i_txclk(i_txclk), .i_reset(i_reset), .lnk(ifa));

  mdl_sdevlink #(.NPRIM(2), .TIMEOUT(TO_B), .MAX_RETRY(0), .SYNC_CNT(1), .ALIGN_INTV(INTV))
    u_dut_b (.i_txclk(i_txclk), .i_reset(i_reset), .lnk(ifb));

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_txclk);
    @(negedge i_txclk);
  endtask

  function automatic logic [6:0] st_a();
    return {ifa.o_cominit, ifa.o_comwake, ifa.o_tx_oob, ifa.o_tx_ready,
            ifa.o_link_up, ifa.o_reset, ifa.o_error};
  endfunction

  function automatic logic [6:0] st_b();
    return {ifb.o_cominit, ifb.o_comwake, ifb.o_tx_oob, ifb.o_tx_ready,
            ifb.o_link_up, ifb.o_reset, ifb.o_error};
  endfunction

  // near-misses of ALIGN/SYNC catch partial compares
  function automatic logic [39:0] junk40();
    logic [39:0] w;
    case ($urandom_range(0, 2))
      0:       w = ALIGN_P ^ (40'd1 << $urandom_range(0, 39));
      1:       w = SYNC_P ^ (40'd1 << $urandom_range(0, 39));
      default: w = {8'($urandom), $urandom};
    endcase
    if (w == ALIGN_P || w == SYNC_P) w = ~w;
    return w;
  endfunction

  task automatic pulse_a_comreset();
    ifa.i_comreset = 1'b1;
    ifa.i_comwake  = 1'($urandom_range(0, 1));
    ifa.i_oob_done = 1'($urandom_range(0, 1));
    tick();
    ifa.i_comreset = 1'b0;
    ifa.i_comwake  = 1'b0;
    ifa.i_oob_done = 1'b0;
  endtask

  task automatic reach_align_a();
    pulse_a_comreset();
    ifa.i_oob_done = 1'b1; tick(); ifa.i_oob_done = 1'b0;
    ifa.i_comwake  = 1'b1; tick(); ifa.i_comwake  = 1'b0;
    ifa.i_oob_done = 1'b1; tick(); ifa.i_oob_done = 1'b0;
    check("reach_align", {st_a(), ifa.o_tx_data}, {S_LINE, ALIGN_P});
  endtask

  // sync pattern as a bit queue: 1 = SYNC word, 0 = other word
  task automatic bringup_a(input bit fixed_pat);
    bit q[$];
    int d;
    int cnt;
    bit up;
    pulse_a_comreset();
    check("init_pulse", {st_a(), ifa.o_retries}, {S_INIT, 2'd0});
    d = $urandom_range(0, 4);
    repeat (d) begin
      ifa.i_comwake = 1'($urandom_range(0, 1));
      tick();
      ifa.i_comwake = 1'b0;
      check("init_wait", st_a(), S_IDLE);
    end
    ifa.i_oob_done = 1'b1; tick(); ifa.i_oob_done = 1'b0;
    d = $urandom_range(0, TO_A - 4);
    repeat (d) begin
      ifa.i_oob_done = 1'($urandom_range(0, 1));
      tick();
      ifa.i_oob_done = 1'b0;
    end
    check("await_wake", st_a(), S_IDLE);
    ifa.i_comwake = 1'b1; tick(); ifa.i_comwake = 1'b0;
    check("wake_pulse", st_a(), S_WAKE);
    d = $urandom_range(0, 4);
    repeat (d) begin
      ifa.i_comwake = 1'($urandom_range(0, 1));
      tick();
      ifa.i_comwake = 1'b0;
      check("wake_wait", st_a(), S_IDLE);
    end
    ifa.i_oob_done = 1'b1; tick(); ifa.i_oob_done = 1'b0;
    check("align_tx", {st_a(), ifa.o_tx_data}, {S_LINE, ALIGN_P});
    d = $urandom_range(0, 5);
    repeat (d) begin
      ifa.i_rx_data = junk40();
      tick();
      check("align_hold", {st_a(), ifa.o_tx_data}, {S_LINE, ALIGN_P});
    end
    ifa.i_rx_data = ALIGN_P;
    tick();
    check("sync_tx", {st_a(), ifa.o_tx_data}, {S_LINE, SYNC_P});

    if (fixed_pat) q = '{1, 1, 1, 0, 1, 1, 1, 1};
    else begin
      d = $urandom_range(0, 6);
      repeat (d) q.push_back(1'($urandom_range(0, 1)));
      repeat (SC_A) q.push_back(1'b1);
    end
    cnt = 0;
    up  = 1'b0;
    foreach (q[i]) begin
      if (!up) begin
        ifa.i_rx_data = q[i] ? SYNC_P : junk40();
        cnt = q[i] ? cnt + 1 : 0;
        up  = (cnt == SC_A);
        tick();
        if (up) check("link_up", st_a(), S_UP);
        else    check("sync_wait", {st_a(), ifa.o_tx_data}, {S_LINE, SYNC_P});
        if (fixed_pat && up) check("sync_idx", i, 7);
      end
    end
  endtask

  task automatic stream_a(input int n);
    logic [39:0] w;
    logic [39:0] exp_d = '0;
    bit          have_d = 1'b0;
    bit          exp_rdy = 1'b1;
    int          hold = 0;
    int          cons = 0;
    for (int i = 0; i < n; i++) begin
      w = {8'($urandom), $urandom};
      ifa.i_tx_data = w;
      check("tx_ready", ifa.o_tx_ready, exp_rdy);
      if (have_d) check("tx_data", ifa.o_tx_data, exp_d);
      if (exp_rdy) begin
        exp_d = w;
        cons++;
        if (INS_EN && cons % INTV == 0) hold = 2;
      end else begin
        exp_d = ALIGN_P;
        hold--;
      end
      have_d  = 1'b1;
      exp_rdy = (hold == 0);
      tick();
    end
    check("ready_hold", st_a() & 7'b0011110, 7'b0001100);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [79:0] wb;
    ifa.i_comreset = 1'b0; ifa.i_comwake = 1'b0; ifa.i_oob_done = 1'b0;
    ifa.i_rx_data  = '0;   ifa.i_tx_data = '0;
    ifb.i_comreset = 1'b0; ifb.i_comwake = 1'b0; ifb.i_oob_done = 1'b0;
    ifb.i_rx_data  = '0;   ifb.i_tx_data = '0;
    i_reset = 1'b1;
    repeat (3) tick();
    i_reset = 1'b0;
    tick();
    check("rst_a", {st_a(), ifa.o_retries, ifa.o_tx_data}, {S_IDLE, 2'd0, 40'd0});
    check("rst_b", {st_b(), ifb.o_retries, ifb.o_tx_data}, {S_IDLE, 1'b0, 80'd0});

    // deterministic SYNC pattern with one break, then randomised bring-ups
    bringup_a(1'b1);
    stream_a(20);
    ifa.i_comreset = 1'b1; ifa.i_comwake = 1'b1; ifa.i_oob_done = 1'b1;
    tick();
    ifa.i_comreset = 1'b0; ifa.i_comwake = 1'b0; ifa.i_oob_done = 1'b0;
    check("rst_in_ready", {st_a(), ifa.o_retries}, {S_INIT, 2'd0});
    for (int k = 0; k < 3; k++) begin
      bringup_a(1'b0);
      stream_a($urandom_range(12, 30));
    end

    // AWAIT_ALIGN and AWAIT_SYNC timeouts return to IDLE
    reach_align_a();
    repeat (TO_A - 1) begin ifa.i_rx_data = junk40(); tick(); end
    check("align_tmo_pre", st_a(), S_LINE);
    tick();
    check("align_tmo", {st_a(), ifa.o_tx_data}, {S_IDLE, 40'd0});
    repeat (3) begin
      ifa.i_comwake = 1'b1; ifa.i_oob_done = 1'b1; tick();
      ifa.i_comwake = 1'b0; ifa.i_oob_done = 1'b0;
      check("idle_ignore", st_a(), S_IDLE);
    end
    reach_align_a();
    ifa.i_rx_data = ALIGN_P; tick();
    repeat (TO_A - 1) begin ifa.i_rx_data = junk40(); tick(); end
    check("sync_tmo_pre", {st_a(), ifa.o_tx_data}, {S_LINE, SYNC_P});
    tick();
    check("sync_tmo", st_a(), S_IDLE);

    // COMINIT retries without COMWAKE, then ERROR
    ifa.i_comreset = 1'b1; tick(); ifa.i_comreset = 1'b0;
    for (int k = 0; k <= MR_A; k++) begin
      check("retry_pulse", {ifa.o_cominit, ifa.o_retries}, {1'b1, 2'(k)});
      ifa.i_oob_done = 1'b1; tick(); ifa.i_oob_done = 1'b0;
      n = 1;
      while (n < 4 * TO_A && !ifa.o_cominit && !ifa.o_error) begin tick(); n++; end
      check("retry_gap", n, TO_A + 1);
    end
    check("error_set", {st_a(), ifa.o_retries}, {S_ERR, 2'(MR_A)});
    repeat (4) begin
      ifa.i_comwake = 1'($urandom_range(0, 1)); ifa.i_oob_done = 1'($urandom_range(0, 1));
      tick();
      ifa.i_comwake = 1'b0; ifa.i_oob_done = 1'b0;
      check("error_hold", st_a(), S_ERR);
    end
    ifa.i_comreset = 1'b1; tick(); ifa.i_comreset = 1'b0;
    check("error_exit", {st_a(), ifa.o_retries}, {S_INIT, 2'd0});

    // DUT B: MAX_RETRY=0 goes straight to ERROR
    ifb.i_comreset = 1'b1; tick(); ifb.i_comreset = 1'b0;
    ifb.i_oob_done = 1'b1; tick(); ifb.i_oob_done = 1'b0;
    n = 1;
    while (n < 4 * TO_B && !ifb.o_cominit && !ifb.o_error) begin tick(); n++; end
    check("b_err_gap", n, TO_B + 1);
    check("b_err", {st_b(), ifb.o_retries}, {S_ERR, 1'b0});

    // DUT B: two-primitive words, partial matches do not advance
    ifb.i_comreset = 1'b1; tick(); ifb.i_comreset = 1'b0;
    ifb.i_oob_done = 1'b1; tick(); ifb.i_oob_done = 1'b0;
    ifb.i_comwake  = 1'b1; tick(); ifb.i_comwake  = 1'b0;
    check("b_wake", st_b(), S_WAKE);
    ifb.i_oob_done = 1'b1; tick(); ifb.i_oob_done = 1'b0;
    check("b_align_tx", {st_b(), ifb.o_tx_data}, {S_LINE, ALIGN_P, ALIGN_P});
    ifb.i_rx_data = {junk40(), ALIGN_P}; tick();
    ifb.i_rx_data = {ALIGN_P, junk40()}; tick();
    check("b_half_align", {st_b(), ifb.o_tx_data}, {S_LINE, ALIGN_P, ALIGN_P});
    ifb.i_rx_data = {ALIGN_P, ALIGN_P}; tick();
    check("b_sync_tx", {st_b(), ifb.o_tx_data}, {S_LINE, SYNC_P, SYNC_P});
    ifb.i_rx_data = {junk40(), SYNC_P}; tick();
    check("b_half_sync", st_b(), S_LINE);
    ifb.i_rx_data = {SYNC_P, SYNC_P}; tick();
    check("b_link_up", st_b(), S_UP);
    wb = {16'($urandom), $urandom, $urandom};
    ifb.i_tx_data = wb; tick();
    check("b_tx_data", ifb.o_tx_data, wb);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
